// File: rtl/uart_pkg.sv
// Shared UART scheduler types: dispatcher states, byte payload and arbiter result.
package uart_pkg;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned REQ_IDX_W       = 3;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    GUARD,
    IDLE,
    WAIT
  } sched_state_t;

  typedef struct packed {
    logic                 hit;
    logic [REQ_IDX_W-1:0] idx;
  } arb_pick_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side valid/ready byte bus for the UART transmit scheduler.
interface uart_tx_scheduler_if #(
  parameter int unsigned NREQ = 2
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head is visible combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_data = mem[rd_ptr];
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);

  // Storage needs no reset; only pointers and level define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbitration of NREQ byte sources into a FIFO, dispatched to a
// reset-less UART transmitter with one start pulse per FRAME_CYCLES.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned T            = 2604,
  parameter int unsigned FRAME_CYCLES = UART_FRAME_BITS * T + 2,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  uart_tx_scheduler_if.slave     req,
  output byte_t                  tx_data,
  output logic                   tx_start,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned CNT_W = $clog2(FRAME_CYCLES + 1);

  // First valid requester at or after ptr, scanning upward with wrap.
  function automatic arb_pick_t arb_pick(input logic [NREQ-1:0]      valid,
                                         input logic [REQ_IDX_W-1:0] ptr);
    arb_pick_t       pick;
    logic [NREQ-1:0] rot;
    int              idx;
    pick = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      rot = valid >> idx;
      if (rot[0]) begin
        pick.hit = 1'b1;
        pick.idx = REQ_IDX_W'(idx);
      end
    end
    return pick;
  endfunction

  logic [REQ_IDX_W-1:0] rr_ptr;
  logic                 arb_en;
  arb_pick_t            pick_c;
  logic [NREQ-1:0]      grant_c;
  logic                 push_c;
  byte_t                push_data_c;
  logic                 pop_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  byte_t                fifo_head;

  sched_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  byte_t                tx_data_d;
  logic                 tx_start_d;
  logic                 tx_busy_d;
  logic                 cnt_last_c;
  logic                 issue_c;

  // arb_en keeps req_ready low while reset is applied.
  assign pick_c      = arb_pick(req.req_valid, rr_ptr);
  assign grant_c     = (arb_en && pick_c.hit && !fifo_full) ? (NREQ'(1) << pick_c.idx) : '0;
  assign req.req_ready = grant_c;
  assign push_c      = |grant_c;
  assign push_data_c = byte_t'(req.req_data >> {pick_c.idx, 3'b000});

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rr_ptr <= '0;
      arb_en <= 1'b0;
    end else begin
      arb_en <= 1'b1;
      if (push_c) begin
        rr_ptr <= (pick_c.idx == REQ_IDX_W'(NREQ - 1)) ? '0 : pick_c.idx + REQ_IDX_W'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= GUARD;
      cnt_q    <= CNT_W'(FRAME_CYCLES);
      tx_data  <= '0;
      tx_start <= 1'b0;
      tx_busy  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_data  <= tx_data_d;
      tx_start <= tx_start_d;
      tx_busy  <= tx_busy_d;
    end
  end

  // WAIT reissues directly at terminal count so back-to-back starts sit exactly FRAME_CYCLES apart.
  assign cnt_last_c = (cnt_q == CNT_W'(1));
  assign issue_c    = !fifo_empty && ((state_q == IDLE) || ((state_q == WAIT) && cnt_last_c));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    tx_busy_d  = tx_busy;
    pop_c      = 1'b0;
    if (issue_c) begin
      pop_c      = 1'b1;
      tx_data_d  = fifo_head;
      tx_start_d = 1'b1;
      tx_busy_d  = 1'b1;
      cnt_d      = CNT_W'(FRAME_CYCLES);
      state_d    = WAIT;
    end else begin
      case (state_q)
        GUARD, WAIT: begin
          if (cnt_last_c) begin
            state_d   = IDLE;
            cnt_d     = '0;
            tx_busy_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        IDLE:    tx_busy_d = 1'b0;
        default: state_d = GUARD;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART byte transmitter among NREQ requesters.
- Round-robin arbitration feeds accepted bytes into a small FIFO.
- A dispatcher then presents one byte at a time to the transmitter using a one-cycle start pulse, spaced by the full frame duration.
- The transmitter has no busy output and no reset, so the scheduler owns frame timing and is the only agent that drives the transmitter's data/start inputs.

Parameters:
- NREQ, 2: number of requesters (2..8).
- T, 2604: clock cycles per UART bit; must match the transmitter instance.
- FRAME_CYCLES, 10*T+2: minimum clock-edge spacing between consecutive tx_start pulses.
- DEPTH, 16: FIFO entries (power of two, ≥2).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a byte.
- req_data  in  NREQ*8  byte of requester i in bits [8i+7:8i].
- req_ready  out  NREQ  one-hot or zero; byte of requester i accepted at this edge when valid&ready.
- tx_data  out  8  byte to transmitter data input; held stable from its tx_start until the next tx_start.
- tx_start  out  1  one-cycle pulse to transmitter start input.
- tx_busy  out  1  high while a frame is in flight or during the post-reset guard.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RSTN low, asynchronous):
  - Outputs: tx_start=0, tx_data=8'h00, req_ready=0, fifo_level=0, tx_busy=1.
  - State: FIFO emptied, RR pointer=0, FSM=GUARD, counter=FRAME_CYCLES.
- Arbiter (combinational from registered state):
  - If FIFO not full, grant the first valid requester scanning from the RR pointer upward with wrap; req_ready = one-hot grant.
  - If FIFO is full, req_ready=0.
  - On an accepted byte, push it and set RR pointer = granted index+1 mod NREQ. With no accept, the pointer holds.
  - Valid must not depend on ready. Data need be stable only in the accept cycle.
- FIFO:
  - Push and pop in the same cycle are allowed; level is unchanged.
  - Push while full is impossible (ready=0).
  - Pop occurs only from dispatcher ISSUE. Pointers wrap modulo DEPTH.
- Dispatcher FSM:
  - GUARD: counts down FRAME_CYCLES; on reaching 0 → IDLE. Covers a frame possibly in flight in the unreset transmitter.
  - IDLE: tx_busy=0. If FIFO is non-empty at the edge, pop the head into tx_data, set tx_start=1 for the next cycle only, and → WAIT.
  - WAIT: tx_busy=1. Counter runs so that consecutive tx_start assertions are exactly FRAME_CYCLES cycles apart when the FIFO stays non-empty; → IDLE at terminal count.
- Latency: a byte pushed into an empty FIFO while the FSM is IDLE produces tx_start two cycles after the accept edge (push edge, then pop/issue edge), with tx_data valid in the same cycle as tx_start.
- tx_start is never high in two consecutive cycles and never high in GUARD.
- Bytes from one requester leave in acceptance order. No byte is dropped or duplicated.
- Reset mid-frame: FIFO contents are discarded and the GUARD wait is repeated in full.

Decomposition:
- Package uart_pkg:
  - sched_state_t enum {GUARD, IDLE, WAIT}.
  - byte_t = logic[7:0].
  - UART_FRAME_BITS = 10, shared with transmitter-side code.
- Sub-module sync_fifo: parameterised by WIDTH and DEPTH, with push, pop, full, empty and level. Reusable for a receive path.
- The arbiter stays inline (function over the valid vector and pointer).

Test Plan (T=4, FRAME_CYCLES=42, DEPTH=4, NREQ=2, transmitter instance attached, UART_TX decoded by a bench monitor):
- Reset release, no requests → tx_busy high for 42 cycles then low; tx_start never asserted; UART_TX constant 1.
- After guard, req0 sends 8'hA5 once → tx_start 2 cycles after accept, tx_data=A5; monitor decodes A5 (start 0, LSB first, stop 1); tx_busy low again 42 cycles after tx_start.
- Both requesters valid continuously, req0 bytes 01,02,03 and req1 bytes 11,12,13 → accept order 01,11,02,12,03,13; tx_start spacing exactly 42 cycles; decoded stream identical.
- Stall the dispatcher with 6 bytes from req0 pushed back-to-back → fifo_level reaches 4, req_ready deasserts, no byte lost; all 6 decoded in order.
- Simultaneous push and pop at level 2 → level stays 2, head byte transmitted, new byte at tail.
- RSTN pulsed low mid-WAIT with 3 bytes queued → outputs reset immediately; fifo_level=0; 42-cycle guard; none of the 3 bytes ever transmitted.
